// File: rtl/data_memory_ws.sv
// rtl/data_memory_ws.sv - word-organised data memory with wait states, byte strobes and ready/ack handshake
module data_memory_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int BYTE_ADDR   = 1
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                re,
  input  logic                we,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                wack,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int SHIFT = (BYTE_ADDR != 0 && NB > 1) ? $clog2(NB) : 0;
  localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              re_q, we_q;
  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;

  logic [ADDR_W-1:0] ridx, widx;
  logic [IDX_W-1:0]  ridx_t, widx_t;
  logic              r_in, w_in, complete;
  logic [DATA_W-1:0] merged, rd_word;

  assign ready    = (state == S_IDLE);
  assign ridx     = raddr_q >> SHIFT;
  assign widx     = waddr_q >> SHIFT;
  assign ridx_t   = ridx[IDX_W-1:0];
  assign widx_t   = widx[IDX_W-1:0];
  // Range check at full address width so high address bits can never alias into the array
  assign r_in     = ({1'b0, ridx} < DEPTH_X);
  assign w_in     = ({1'b0, widx} < DEPTH_X);
  assign complete = (state == S_WAIT) && (cnt == '0);

  // Merged word doubles as the write-before-read result for a combined same-index access
  always_comb begin
    merged = w_in ? mem[widx_t] : '0;
    for (int i = 0; i < NB; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
    rd_word = '0;
    if (r_in) rd_word = (we_q && w_in && ridx == widx) ? merged : mem[ridx_t];
  end

  always_ff @(posedge clk) begin
    if (!sys_rst && complete && we_q && w_in) mem[widx_t] <= merged;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (re || we) begin
            re_q    <= re;
            we_q    <= we;
            raddr_q <= raddr;
            waddr_q <= waddr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            cnt     <= CNT_W'(WAIT_CYCLES);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_IDLE;
            if (re_q) begin
              rdata  <= rd_word;
              rvalid <= 1'b1;
            end
            wack <= we_q;
            err  <= (re_q && !r_in) || (we_q && !w_in);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// tb/tb_data_memory_ws.sv - table, directed and randomized checks of data_memory_ws against a word-array model
module tb_data_memory_ws;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        re, we;
  logic [31:0] raddr, waddr, wdata;
  logic [3:0]  wstrb;
  logic        ready, rvalid, wack, err;
  logic [31:0] rdata;

  logic        re0, we0;
  logic [31:0] raddr0, waddr0, wdata0;
  logic [3:0]  wstrb0;
  logic        ready0, rvalid0, wack0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  data_memory_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(2), .BYTE_ADDR(1)) dut (
    .clk(clk), .sys_rst(sys_rst), .re(re), .we(we), .raddr(raddr), .waddr(waddr),
    .wdata(wdata), .wstrb(wstrb), .ready(ready), .rdata(rdata), .rvalid(rvalid),
    .wack(wack), .err(err)
  );

  data_memory_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0), .BYTE_ADDR(1)) dut0 (
    .clk(clk), .sys_rst(sys_rst), .re(re0), .we(we0), .raddr(raddr0), .waddr(waddr0),
    .wdata(wdata0), .wstrb(wstrb0), .ready(ready0), .rdata(rdata0), .rvalid(rvalid0),
    .wack(wack0), .err(err0)
  );

  typedef struct {
    logic        r, w;
    logic [31:0] ra, wa, wd;
    logic [3:0]  ws;
    logic [31:0] ed;
    logic        ev, ew, ee;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] mdl [DEPTH];
  logic [31:0] hold;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: memory is a plain word array, the write lands before the read is looked up
  task automatic model_txn(input logic r, input logic w, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [31:0] wd, input logic [3:0] ws,
                           output logic [31:0] ed, output logic ee);
    logic [31:0] ri, wi;
    ri = ra / 4;
    wi = wa / 4;
    ee = (r && ri >= DEPTH) || (w && wi >= DEPTH);
    if (w && wi < DEPTH)
      for (int b = 0; b < 4; b++) if (ws[b]) mdl[wi][8*b +: 8] = wd[8*b +: 8];
    if (r) hold = (ri < DEPTH) ? mdl[ri] : 32'h0;
    ed = hold;
  endtask

  // Called on a negedge with ready=1; returns on the negedge where the ack is visible
  task automatic run_txn(input logic r, input logic w, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [3:0] ws,
                         output logic [31:0] o_rdata, output logic o_rvalid, output logic o_wack,
                         output logic o_err, output logic o_ready, output int lat, output int rdy_low);
    re = r; we = w; raddr = ra; waddr = wa; wdata = wd; wstrb = ws;
    @(posedge clk);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    lat = 0;
    rdy_low = 0;
    while (!(rvalid || wack) && lat < 20) begin
      if (!ready) rdy_low++;
      @(negedge clk);
      lat++;
    end
    o_rdata = rdata; o_rvalid = rvalid; o_wack = wack; o_err = err; o_ready = ready;
  endtask

  initial begin
    logic [31:0] g_rdata, e_rdata;
    logic        g_rv, g_wa, g_err, g_rdy, e_err, r, w;
    logic [31:0] ra, wa, wd;
    logic [3:0]  ws;
    int          lat, rlow, bad, seen;

    for (int i = 0; i < DEPTH; i++) begin
      dut.mem[i] = 32'h0;
      mdl[i] = 32'h0;
    end
    dut.mem[12] = 32'h55AA55AA;
    mdl[12] = 32'h55AA55AA;
    hold = 32'h0;
    re = 0; we = 0; raddr = 0; waddr = 0; wdata = 0; wstrb = 0;
    re0 = 0; we0 = 0; raddr0 = 0; waddr0 = 0; wdata0 = 0; wstrb0 = 0;
    sys_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_rvalid", rvalid, 0);
    check("reset_wack", wack, 0);
    check("reset_err", err, 0);
    check("reset_rdata", rdata, 0);
    sys_rst = 1'b0;
    @(negedge clk);

    vecs[0]  = '{1'b0, 1'b1, 32'h0,        32'h10,  32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0,        32'h10,  32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0,        32'h10,  32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h10,       32'h0,   32'h0,        4'h0, 32'h11BB33DD, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h20,       32'h20,  32'h12345678, 4'h3, 32'h00005678, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h400,      32'h0,   32'h0,        4'h0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h0,        32'h400, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h10,       32'h400, 32'h0,        4'hF, 32'h11BB33DD, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h13,       32'h0,   32'h0,        4'h0, 32'h11BB33DD, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0,        32'h20,  32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h20,       32'h0,   32'h0,        4'h0, 32'h00005678, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0,        32'h3FC, 32'hA5A50001, 4'hF, 32'h00005678, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h3FF,      32'h0,   32'h0,        4'h0, 32'hA5A50001, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,   32'h0,        4'h0, 32'h00000000, 1'b1, 1'b0, 1'b1};

    foreach (vecs[k]) begin
      model_txn(vecs[k].r, vecs[k].w, vecs[k].ra, vecs[k].wa, vecs[k].wd, vecs[k].ws, e_rdata, e_err);
      run_txn(vecs[k].r, vecs[k].w, vecs[k].ra, vecs[k].wa, vecs[k].wd, vecs[k].ws,
              g_rdata, g_rv, g_wa, g_err, g_rdy, lat, rlow);
      check($sformatf("vec%0d_rvalid", k), g_rv, vecs[k].ev);
      check($sformatf("vec%0d_wack", k), g_wa, vecs[k].ew);
      check($sformatf("vec%0d_err", k), g_err, vecs[k].ee);
      check($sformatf("vec%0d_rdata", k), g_rdata, vecs[k].ed);
      check($sformatf("vec%0d_latency", k), lat, 3);
      check($sformatf("vec%0d_ready_low", k), rlow, 3);
      check($sformatf("vec%0d_ready_at_ack", k), g_rdy, 1);
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", k), {rvalid, wack, err}, 3'b000);
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.mem[i] !== mdl[i]) bad++;
    check("mem_after_table", bad, 0);

    // Back-to-back random traffic issued in the ack cycle
    for (int n = 0; n < 150; n++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h47F));
      wa = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom_range(0, 32'h47F));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      model_txn(r, w, ra, wa, wd, ws, e_rdata, e_err);
      run_txn(r, w, ra, wa, wd, ws, g_rdata, g_rv, g_wa, g_err, g_rdy, lat, rlow);
      check($sformatf("rnd%0d_acks", n), {g_rv, g_wa, g_err}, {r, w, e_err});
      check($sformatf("rnd%0d_rdata", n), g_rdata, e_rdata);
      check($sformatf("rnd%0d_latency", n), lat, 3);
    end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.mem[i] !== mdl[i]) bad++;
    check("mem_after_random", bad, 0);

    // Reset while a write to 0x30 is pending must not commit it
    we = 1'b1; waddr = 32'h30; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    check("rst_mid_ready_low", ready, 0);
    sys_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    check("rst_mid_ready", ready, 1);
    check("rst_mid_rdata", rdata, 0);
    hold = 32'h0;
    seen = 0;
    repeat (5) begin
      if (wack || rvalid || err) seen++;
      @(negedge clk);
    end
    check("rst_mid_no_ack", seen, 0);
    check("rst_mid_mem12", dut.mem[12], mdl[12]);
    model_txn(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 4'h0, e_rdata, e_err);
    run_txn(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 4'h0, g_rdata, g_rv, g_wa, g_err, g_rdy, lat, rlow);
    check("rst_mid_readback", g_rdata, e_rdata);
    check("rst_mid_readback_rvalid", g_rv, 1);

    // Zero-wait instance with a continuously held write request
    @(negedge clk);
    we0 = 1'b1; waddr0 = 32'h8; wdata0 = 32'h0BADCAFE; wstrb0 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("w0_ready_%0d", k), ready0, (k % 2 == 1) ? 1 : 0);
      check($sformatf("w0_wack_%0d", k), wack0, (k % 2 == 1) ? 1 : 0);
    end
    we0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w0_mem", dut0.mem[2], 32'h0BADCAFE);
    check("w0_idle", {ready0, wack0, rvalid0, err0}, 4'b1000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
- Parametrised successor to the combinational DataMemory; sits between RiscV_processor's dmem port and a word-organised storage array.
- Adds a configurable number of wait states, byte write strobes, out-of-range error reporting, and a ready/ack handshake.
- The processor stalls on `ready` so the pipeline can run against slower memory models.
- Read and write addresses stay separate, matching the processor's raddr_dmem/waddr_dmem split.

Parameters:
- DATA_W, 32, data word width; must be a multiple of 8.
- ADDR_W, 32, address width of raddr/waddr.
- DEPTH, 256, number of DATA_W words in the array.
- WAIT_CYCLES, 2, extra cycles between accept and completion (0 allowed).
- BYTE_ADDR, 1, 1: addresses are byte addresses (word index = addr >> log2(DATA_W/8)); 0: addresses are word indices.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- re  in  1  read request.
- we  in  1  write request.
- raddr  in  ADDR_W  read address.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write enables; bit i covers wdata[8i+7:8i].
- ready  out  1  high when a request can be accepted (state IDLE).
- rdata  out  DATA_W  read data; valid while rvalid=1, held until the next read completes.
- rvalid  out  1  one-cycle pulse: read completed.
- wack  out  1  one-cycle pulse: write completed (committed or dropped).
- err  out  1  one-cycle pulse with rvalid/wack when any address of the completed transaction was out of range.

Behaviour:
- Interface: one clock `clk`; reset `sys_rst` is synchronous and active-high.
- Reset values: state IDLE, cnt 0, rdata 0, rvalid 0, wack 0, err 0. The storage array is not cleared; benches initialise it hierarchically through `mem`.
- States: IDLE and WAIT. `ready = (state == IDLE)`, combinational from state.
- Accept:
  - Occurs at an edge where state=IDLE and (re|we)=1.
  - Latch re, we, raddr, waddr, wdata, wstrb.
  - Load cnt=WAIT_CYCLES and go to WAIT.
- Requests sampled while state=WAIT are ignored. The master must hold its request until ready=1.
- WAIT:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: complete the transaction and return to IDLE.
- Latency: accept at edge E0 → completion at edge E(WAIT_CYCLES+1). rvalid/wack are high in the following cycle, in which state is already IDLE.
- Throughput: the earliest next accept is edge E(WAIT_CYCLES+2), so back-to-back issue is possible in the ack cycle.
- Completion, write:
  - For each i with wstrb[i]=1, mem[widx] byte i <= wdata byte i; other bytes are unchanged.
  - wack <= 1.
  - wstrb=0 is a legal no-op write and still pulses wack.
- Completion, read: rdata <= mem[ridx]; rvalid <= 1.
- Simultaneous re and we:
  - Form one transaction; rvalid and wack pulse in the same cycle.
  - If ridx==widx, rdata returns the merged word: strobed bytes from wdata, the rest from old mem. This is write-before-read.
- Index: ridx/widx = addr >> log2(DATA_W/8) when BYTE_ADDR=1, else addr. Low byte-offset bits are ignored; misaligned access is not supported.
- Out of range (idx >= DEPTH):
  - Write is dropped, wack and err still pulse.
  - Read returns rdata=0 with rvalid and err.
  - err is the OR over both halves of a combined transaction.
- rvalid, wack and err are 0 in every cycle except the single completion cycle.
- Reset mid-operation: the pending transaction is abandoned and its write is not committed; the block returns to IDLE with no ack pulse.
- Width rules: cnt width = max(1, clog2(WAIT_CYCLES+1)). Index comparison is done at full ADDR_W width, with no truncation before the range check.

Test Plan:
- WAIT_CYCLES=2, write waddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, then read raddr=0x10 → ready low 3 cycles per txn; wack 3 edges after write accept; rvalid 3 edges after read accept with rdata=0xDEADBEEF.
- Byte strobes: mem[4]=0x11223344, write waddr=0x10, wdata=0xAABBCCDD, wstrb=4'b0101 → read gives 0x11BB33DD.
- Combined re=we=1, same address 0x20, old 0x00000000, wdata=0x12345678, wstrb=4'b0011 → one completion cycle with rvalid=wack=1, rdata=0x00005678.
- Out of range: read raddr=0x400 (idx 256, DEPTH=256) → rvalid=1, err=1, rdata=0. Write waddr=0x400 → wack=1, err=1, no mem word changed.
- WAIT_CYCLES=0 sweep: request held continuously → accepts every 2 edges, ack one edge after each accept, ready toggling 0/1.
- Reset during WAIT of a write to 0x30 (data 0xCAFEF00D) → after sys_rst: ready=1, no wack, mem[12] keeps its prior value; a subsequent read returns the prior value.
